cursor_depth_ctrl: RTL and testbench

- Frame-rate depth controller that produces pos_z for the cursor render stage, which draws the paddle rectangle scaled by depth.
- Converts held player keys into smooth depth motion with a velocity ramp, braking, saturation at the playfield depth limits, and an auto-recenter command.
- Updates once per frame_clk rising edge; pos_z is stable for the whole frame the renderer draws.

---
 rtl/cursor_depth_pkg.sv | 30 +++
 rtl/cursor_depth_ctrl_frame_tick_gen.sv | 52 +++++
 rtl/cursor_depth_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_cursor_depth_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cursor_depth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cursor_depth_pkg
//  Description : Shared widths, default depth limits and the motion state
//                encoding for the cursor depth controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package cursor_depth_pkg;

    localparam int POS_W = 10;                 // pos_z width (unsigned)
    localparam int VEL_W = 5;                  // vel_z width (signed)
    localparam int SUM_W = POS_W + 1;          // signed width for pos + vel
    localparam int SPD_W = VEL_W - 1;          // unsigned speed magnitude

    localparam int DEF_Z_MIN        = 0;
    localparam int DEF_Z_MAX        = 128;
    localparam int DEF_Z_CENTER     = 64;
    localparam int DEF_V_MAX        = 8;
    localparam int DEF_ACCEL_FRAMES = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACCEL    = 3'd1,
        CRUISE   = 3'd2,
        BRAKE    = 3'd3,
        RECENTER = 3'd4
    } state_t;

endpackage : cursor_depth_pkg
`default_nettype wire

// File: rtl/cursor_depth_ctrl_frame_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tick_gen
//  Description : Turns frame_clk rising edges into single-Clk tick pulses.
//                Optional macro CURSOR_DEPTH_FRAME_SYNC_EN inserts a 2-flop
//                synchronizer ahead of the edge detector (latency 3 Clk
//                instead of 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic i_frame_clk,
    output logic o_tick
);

    logic w_frame;
    logic r_frame_q;

`ifdef CURSOR_DEPTH_FRAME_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-stage synchronizer for a frame strobe from an unrelated domain
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_frame_clk;
            r_sync2 <= r_sync1;
        end
    end

    assign w_frame = r_sync2;
`else
    assign w_frame = i_frame_clk;
`endif

    // Frame strobe history for rising-edge detection
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_frame_q <= 1'b0;
        end else begin
            r_frame_q <= w_frame;
        end
    end

    assign o_tick = w_frame & ~r_frame_q;

endmodule : frame_tick_gen
`default_nettype wire

// File: rtl/cursor_depth_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cursor_depth_ctrl
//  Description : Per-frame depth controller for the cursor. Held keys drive a
//                velocity ramp with braking, the position saturates at the
//                playfield depth limits, and center_req recenters the cursor.
//                Optional macro CURSOR_DEPTH_FRAME_SYNC_EN synchronizes
//                frame_clk before edge detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module cursor_depth_ctrl
    import cursor_depth_pkg::*;
#(
    parameter int Z_MIN        = DEF_Z_MIN,
    parameter int Z_MAX        = DEF_Z_MAX,
    parameter int Z_CENTER     = DEF_Z_CENTER,
    parameter int V_MAX        = DEF_V_MAX,
    parameter int ACCEL_FRAMES = DEF_ACCEL_FRAMES
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_clk,
    input  logic                    key_in,
    input  logic                    key_out,
    input  logic                    center_req,
    output logic [POS_W-1:0]        pos_z,
    output logic signed [VEL_W-1:0] vel_z,
    output logic                    at_limit,
    output logic                    moving
);

    localparam int CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

    localparam logic [POS_W-1:0]        c_z_min     = POS_W'(Z_MIN);
    localparam logic [POS_W-1:0]        c_z_max     = POS_W'(Z_MAX);
    localparam logic [POS_W-1:0]        c_z_center  = POS_W'(Z_CENTER);
    localparam logic [POS_W-1:0]        c_v_max_pos = POS_W'(V_MAX);
    localparam logic [VEL_W-1:0]        c_v_max_mag = VEL_W'(V_MAX);
    localparam logic [SPD_W-1:0]        c_v_max_spd = SPD_W'(V_MAX);
    localparam logic [CNT_W-1:0]        c_cnt_last  = CNT_W'(ACCEL_FRAMES - 1);
    localparam logic signed [SUM_W-1:0] c_z_min_s   = SUM_W'(Z_MIN);
    localparam logic signed [SUM_W-1:0] c_z_max_s   = SUM_W'(Z_MAX);

    state_t                    r_state;
    logic [POS_W-1:0]          r_pos;
    logic signed [VEL_W-1:0]   r_vel;
    logic [SPD_W-1:0]          r_speed;
    logic                      r_neg;       // motion sign: 1 = pos_z decreasing
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_at_limit;
    logic                      r_moving;

    logic                      w_tick;
    logic                      w_dir_pos;
    logic                      w_dir_neg;
    logic                      w_match;
    logic [SPD_W-1:0]          w_speed_inc;
    logic [SPD_W-1:0]          w_speed_dec;
    logic                      w_rc_neg;
    logic [POS_W-1:0]          w_rc_dist;
    logic [VEL_W-1:0]          w_rc_mag;
    logic                      w_rc_last;

    state_t                    w_state_nx;
    logic [SPD_W-1:0]          w_speed_nx;
    logic                      w_neg_nx;
    logic [CNT_W-1:0]          w_cnt_nx;
    logic [VEL_W-1:0]          w_mag;
    logic                      w_step_neg;
    logic                      w_brake;

    logic signed [VEL_W-1:0]   w_vel;
    logic signed [SUM_W-1:0]   w_sum;
    logic                      w_sat_lo;
    logic                      w_sat_hi;
    logic [POS_W-1:0]          w_new_pos;

    frame_tick_gen u_tick (
        .Clk         (Clk),
        .Reset       (Reset),
        .i_frame_clk (frame_clk),
        .o_tick      (w_tick)
    );

    // Key decode: both or neither pressed means no direction
    assign w_dir_pos   = key_out & ~key_in;
    assign w_dir_neg   = key_in & ~key_out;
    assign w_match     = r_neg ? w_dir_neg : w_dir_pos;
    assign w_speed_inc = r_speed + SPD_W'(1);
    assign w_speed_dec = r_speed - SPD_W'(1);

    // Recenter step: toward Z_CENTER by min(V_MAX, distance)
    assign w_rc_neg  = (r_pos > c_z_center);
    assign w_rc_dist = w_rc_neg ? (r_pos - c_z_center) : (c_z_center - r_pos);
    assign w_rc_mag  = (w_rc_dist > c_v_max_pos) ? c_v_max_mag : w_rc_dist[VEL_W-1:0];
    assign w_rc_last = (w_rc_dist <= c_v_max_pos);

    // Next-state, speed and step magnitude for the coming frame tick
    always_comb begin
        w_state_nx = r_state;
        w_speed_nx = r_speed;
        w_neg_nx   = r_neg;
        w_cnt_nx   = r_cnt;
        w_mag      = '0;
        w_step_neg = r_neg;
        w_brake    = 1'b0;
        case (r_state)
            IDLE: begin
                w_speed_nx = '0;
                w_cnt_nx   = '0;
                if (center_req && (r_pos != c_z_center)) begin
                    w_state_nx = w_rc_last ? IDLE : RECENTER;
                    w_mag      = w_rc_mag;
                    w_step_neg = w_rc_neg;
                end else if (w_dir_pos && (r_pos != c_z_max)) begin
                    w_state_nx = ACCEL;
                    w_speed_nx = SPD_W'(1);
                    w_neg_nx   = 1'b0;
                    w_mag      = VEL_W'(1);
                    w_step_neg = 1'b0;
                end else if (w_dir_neg && (r_pos != c_z_min)) begin
                    w_state_nx = ACCEL;
                    w_speed_nx = SPD_W'(1);
                    w_neg_nx   = 1'b1;
                    w_mag      = VEL_W'(1);
                    w_step_neg = 1'b1;
                end
            end
            ACCEL: begin
                if (!w_match) begin
                    w_brake = 1'b1;
                end else if (r_cnt == c_cnt_last) begin
                    w_cnt_nx   = '0;
                    w_speed_nx = w_speed_inc;
                    w_mag      = {1'b0, w_speed_inc};
                    if (w_speed_inc >= c_v_max_spd) begin
                        w_state_nx = CRUISE;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                    w_mag    = {1'b0, r_speed};
                end
            end
            CRUISE: begin
                if (!w_match) begin
                    w_brake = 1'b1;
                end else begin
                    w_mag = c_v_max_mag;
                end
            end
            BRAKE: begin
                w_brake = 1'b1;
            end
            RECENTER: begin
                w_state_nx = w_rc_last ? IDLE : RECENTER;
                w_mag      = w_rc_mag;
                w_step_neg = w_rc_neg;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
        // Braking always runs to a stop before any reversal is allowed
        if (w_brake) begin
            w_speed_nx = w_speed_dec;
            w_cnt_nx   = '0;
            w_mag      = {1'b0, w_speed_dec};
            w_state_nx = (w_speed_dec == '0) ? IDLE : BRAKE;
        end
    end

    // Signed step and saturating position adder
    assign w_vel     = w_step_neg ? -w_mag : w_mag;
    assign w_sum     = $signed({1'b0, r_pos}) +
                       $signed({{(SUM_W-VEL_W){w_vel[VEL_W-1]}}, w_vel});
    assign w_sat_lo  = (w_sum < c_z_min_s);
    assign w_sat_hi  = (w_sum > c_z_max_s);
    assign w_new_pos = w_sum[POS_W-1:0];

    // Motion FSM and registered outputs, advanced once per frame tick
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_pos      <= c_z_center;
            r_vel      <= '0;
            r_speed    <= '0;
            r_neg      <= 1'b0;
            r_cnt      <= '0;
            r_at_limit <= 1'b0;
            r_moving   <= 1'b0;
        end else if (w_tick) begin
            if (w_sat_lo || w_sat_hi) begin
                r_state    <= IDLE;
                r_pos      <= w_sat_lo ? c_z_min : c_z_max;
                r_vel      <= '0;
                r_speed    <= '0;
                r_cnt      <= '0;
                r_at_limit <= 1'b1;
                r_moving   <= 1'b0;
            end else begin
                r_state    <= w_state_nx;
                r_pos      <= w_new_pos;
                r_vel      <= w_vel;
                r_speed    <= w_speed_nx;
                r_neg      <= w_neg_nx;
                r_cnt      <= w_cnt_nx;
                r_at_limit <= (w_new_pos == c_z_min) || (w_new_pos == c_z_max);
                r_moving   <= (w_state_nx != IDLE);
            end
        end
    end

    assign pos_z    = r_pos;
    assign vel_z    = r_vel;
    assign at_limit = r_at_limit;
    assign moving   = r_moving;

endmodule : cursor_depth_ctrl
`default_nettype wire

// File: tb/tb_cursor_depth_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cursor_depth_ctrl
//  Description : Directed self-checking bench for cursor_depth_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cursor_depth_ctrl;

`ifdef CURSOR_DEPTH_FRAME_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic              Clk;
    logic              Reset;
    logic              frame_clk;
    logic              key_in;
    logic              key_out;
    logic              center_req;
    logic [9:0]        pos_z;
    logic signed [4:0] vel_z;
    logic              at_limit;
    logic              moving;

    int n_checks = 0;
    int n_errors = 0;

    cursor_depth_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .key_in     (key_in),
        .key_out    (key_out),
        .center_req (center_req),
        .pos_z      (pos_z),
        .vel_z      (vel_z),
        .at_limit   (at_limit),
        .moving     (moving)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic signed [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame strobe pulse; returns on a falling Clk edge with outputs settled
    task automatic frame_tick();
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (LAT) @(posedge Clk);
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic check_state(input string tag, input int p, input int v, input int lim, input int mov);
        check_val({tag, "_pos"}, pos_z, p);
        check_val({tag, "_vel"}, $signed(vel_z), v);
        check_val({tag, "_lim"}, at_limit, lim);
        check_val({tag, "_mov"}, moving, mov);
    endtask

    int up_pos [21] = '{65, 66, 67, 68, 70, 72, 74, 76, 79, 82, 85, 88,
                        92, 96, 100, 104, 109, 114, 119, 124, 128};
    int up_vel [21] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3,
                        4, 4, 4, 4, 5, 5, 5, 5, 0};
    int dn_pos [29] = '{127, 126, 125, 124, 122, 120, 118, 116, 113, 110, 107, 104,
                        100, 96, 92, 88, 83, 78, 73, 68, 62, 56, 50, 44,
                        37, 30, 23, 16, 8};
    int brk_pos [4] = '{95, 97, 98, 98};
    int rc_pos  [5] = '{90, 82, 74, 66, 64};
    int rc_vel  [5] = '{-8, -8, -8, -8, -2};

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset      = 1'b1;
        frame_clk  = 1'b0;
        key_in     = 1'b0;
        key_out    = 1'b0;
        center_req = 1'b0;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check_state("reset", 64, 0, 0, 0);

        // Ramp out of the screen until Z_MAX saturation
        key_out = 1'b1;
        for (int i = 0; i < 21; i++) begin
            frame_tick();
            check_state($sformatf("up%0d", i + 1), up_pos[i], up_vel[i],
                        (i == 20) ? 1 : 0, (i == 20) ? 0 : 1);
        end
        for (int i = 0; i < 2; i++) begin
            frame_tick();
            check_state($sformatf("hold_max%0d", i), 128, 0, 1, 0);
        end

        // Ramp into the screen from Z_MAX until CRUISE at -8
        key_out = 1'b0;
        key_in  = 1'b1;
        for (int i = 0; i < 29; i++) begin
            frame_tick();
            check_state($sformatf("dn%0d", i + 1), dn_pos[i],
                        (i < 28) ? -(i / 4 + 1) : -8, 0, 1);
        end

        // Reset during CRUISE wins on the next Clk edge
        key_in = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check_state("rst_cruise", 64, 0, 0, 0);
        @(negedge Clk);
        Reset = 1'b0;

        // Accelerate to speed 4, then reverse keys: braking, no early reversal
        key_out = 1'b1;
        for (int i = 0; i < 13; i++) begin
            frame_tick();
            check_val($sformatf("acc%0d_pos", i + 1), pos_z, up_pos[i]);
        end
        key_out = 1'b0;
        key_in  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            frame_tick();
            check_state($sformatf("brk%0d", i + 1), brk_pos[i], 3 - i, 0, (i == 3) ? 0 : 1);
        end
        key_in = 1'b0;

        // Recenter from 98 with key_out held throughout
        center_req = 1'b1;
        key_out    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            frame_tick();
            center_req = 1'b0;
            check_state($sformatf("rc%0d", i + 1), rc_pos[i], rc_vel[i], 0, (i == 4) ? 0 : 1);
        end
        key_out = 1'b0;

        // center_req already at center, then both keys: no motion
        center_req = 1'b1;
        frame_tick();
        center_req = 1'b0;
        check_state("rc_at_ctr", 64, 0, 0, 0);
        key_in  = 1'b1;
        key_out = 1'b1;
        frame_tick();
        check_state("both_keys", 64, 0, 0, 0);
        key_in  = 1'b0;

        // Latency from frame_clk rise, then frame_clk held high for 100 Clk
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (LAT - 1) @(posedge Clk);
        #1;
        check_val("lat_before", pos_z, 64);
        @(posedge Clk);
        #1;
        check_val("lat_update", pos_z, 65);
        repeat (100) @(posedge Clk);
        #1;
        check_val("held_high_pos", pos_z, 65);
        check_val("held_high_vel", $signed(vel_z), 1);
        @(negedge Clk);
        frame_clk = 1'b0;
        key_out   = 1'b0;
        repeat (3) @(negedge Clk);
        frame_tick();
        check_state("stop", 65, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cursor_depth_ctrl
`default_nettype wire
